mem_arbiter: RTL

//  Shares one synchronous single-port data RAM between NREQ requesters: port 0 = cpu data port, port 1 = debug/loader.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_pick.sv | 63 ++++++
 rtl/mem_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Purpose : shared types and helpers for the single-port RAM arbiter.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } arb_state_t;

    localparam int MAX_NREQ = 4;
    localparam int IDX_W    = 2;    // enough to index MAX_NREQ requesters

    function automatic logic [MAX_NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Purpose : combinational winner selection among pending requesters.
// Latency : 0 cycles (pure combinational).
// Backpressure : none; the caller decides when a grant is taken.
// Ports   : req (pending mask), rr_ptr (round-robin start index) ->
//           grant_idx (winner), grant_valid (any request pending).
// Config  : MEM_ARB_RR_EN selects round-robin; otherwise the highest index wins.
import mem_arb_pkg::*;

module arb_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

`ifdef MEM_ARB_RR_EN
    // Two passes: first the lowest requester at or above rr_ptr, then wrap to
    // the lowest requester overall. Equivalent to a circular search from rr_ptr.
    logic             hit_hi;
    logic [IDX_W-1:0] idx_hi;
    logic             hit_lo;
    logic [IDX_W-1:0] idx_lo;

    always_comb begin
        hit_hi = 1'b0;
        idx_hi = '0;
        hit_lo = 1'b0;
        idx_lo = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!hit_hi && req[i] && (IDX_W'(i) >= rr_ptr)) begin
                hit_hi = 1'b1;
                idx_hi = IDX_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!hit_lo && req[i]) begin
                hit_lo = 1'b1;
                idx_lo = IDX_W'(i);
            end
        end
        grant_valid = hit_lo;
        grant_idx   = hit_hi ? idx_hi : idx_lo;
    end
`else
    // Fixed priority: later iterations overwrite, so the highest index wins.
    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Purpose : shares one synchronous single-port RAM between NREQ requesters (0 = cpu, 1 = debug).
// Latency : grant in IDLE, RAM access in ACCESS, done/rdata in RESP; 3 cycles per transaction.
// Backpressure : requesters hold req until their done pulse; no pre-emption, arbitration only when idle.
// Ports   : clk/rst (sync, active-high); req/req_we/req_addr/req_wdata packed per requester;
//           done (one-hot pulse), rdata, busy; mem_en/mem_we/mem_addr/mem_wdata/mem_rdata to the RAM.
// Config  : define MEM_ARB_RR_EN for round-robin arbitration (default: fixed, highest index wins).
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            req_we,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       busy,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic [DATA_WIDTH-1:0]      mem_rdata
);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [IDX_W-1:0] owner;
    logic             owner_we;     // mem_we drops in RESP, so remember read/write here
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic [IDX_W-1:0] ptr_next;

    // Unpacked per-requester views sized to MAX_NREQ so a 2-bit index always fits.
    logic                  we_arr   [MAX_NREQ];
    logic [ADDR_WIDTH-1:0] addr_arr [MAX_NREQ];
    logic [DATA_WIDTH-1:0] wdata_arr[MAX_NREQ];

    for (genvar g = 0; g < MAX_NREQ; g++) begin : g_unpack
        if (g < NREQ) begin : g_used
            assign we_arr[g]    = req_we[g];
            assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_tie
            assign we_arr[g]    = 1'b0;
            assign addr_arr[g]  = '0;
            assign wdata_arr[g] = '0;
        end
    end

    arb_pick #(.NREQ(NREQ)) u_pick (
        .req         (req),
        .rr_ptr      (rr_ptr),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Pointer moves past the winner, so a requester that just completed
    // is searched last on the next arbitration.
    assign ptr_next = (grant_idx == IDX_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE:   if (grant_valid) state_next = ARB_ACCESS;
            ARB_ACCESS: state_next = ARB_RESP;
            ARB_RESP:   state_next = ARB_IDLE;
            default:    state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= '0;
            owner_we  <= 1'b0;
            rr_ptr    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        owner     <= grant_idx;
                        owner_we  <= we_arr[grant_idx];
                        rr_ptr    <= ptr_next;
                        mem_en    <= 1'b1;
                        mem_we    <= we_arr[grant_idx];
                        mem_addr  <= addr_arr[grant_idx];
                        mem_wdata <= wdata_arr[grant_idx];
                    end
                end
                ARB_ACCESS: begin
                    // Address/data are left in place; only the strobes drop.
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state != ARB_IDLE);
    assign done  = (state == ARB_RESP) ? NREQ'(onehot(owner)) : '0;
    assign rdata = (state == ARB_RESP && !owner_we) ? mem_rdata : '0;

endmodule
